// File: rtl/fifo_pkg.sv
// Shared FIFO types and helpers: status bundle and non-power-of-two pointer wrap.
package fifo_pkg;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
    logic overflow;
    logic underflow;
  } fifo_status_t;

  // Wraps at depth-1 explicitly so any depth works, not only powers of two.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_ram.sv
// Storage array for sync_fifo: one synchronous write port, one asynchronous read port.
module fifo_ram #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count, threshold flags,
// sticky overflow/underflow and synchronous flush.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned DW        = 16,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AW        = $clog2(DEPTH),
  parameter int unsigned AF_THRESH = DEPTH - 1,
  parameter int unsigned AE_THRESH = 1
) (
  input  logic          clock,
  input  logic          reset_L,
  input  logic          clear,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          empty,
  output logic          full,
  output logic          almost_empty,
  output logic          almost_full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          push, pop, ram_we;
  fifo_status_t  status;

  always_comb begin
    status.empty        = (count_q == '0);
    status.full         = (32'(count_q) == DEPTH);
    status.almost_empty = (32'(count_q) <= AE_THRESH);
    status.almost_full  = (32'(count_q) >= AF_THRESH);
    status.overflow     = overflow_q;
    status.underflow    = underflow_q;
  end

  // A push into a full FIFO is fine when a pop frees the head slot in the same cycle.
  assign push = wr_en && (!status.full || (rd_en && !status.empty));
  assign pop  = rd_en && !status.empty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = AW'(next_ptr(32'(wr_ptr_q), DEPTH));
      end
      if (pop) begin
        rd_ptr_d = AW'(next_ptr(32'(rd_ptr_q), DEPTH));
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
      overflow_d  = overflow_q | (wr_en & ~push);
      underflow_d = underflow_q | (rd_en & status.empty);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_L) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Reset and flush both discard any same-cycle write.
  assign ram_we = push && reset_L && !clear;

  fifo_ram #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign empty        = status.empty;
  assign full         = status.full;
  assign almost_empty = status.almost_empty;
  assign almost_full  = status.almost_full;
  assign overflow     = status.overflow;
  assign underflow    = status.underflow;
  assign count        = count_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed scenarios on a depth-4 instance, then wrap and randomized
// runs on depth-4 and depth-5 instances driven in lockstep against queue models.
module tb_sync_fifo;

  logic       clock;
  logic       reset_L;
  logic       clear;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       rd_en;

  logic [7:0] a_rd_data;
  logic       a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
  logic [2:0] a_count;

  logic [7:0] b_rd_data;
  logic       b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
  logic [3:0] b_count;

  int n_checks;
  int n_fail;

  sync_fifo #(
    .DW        (8),
    .DEPTH     (4),
    .AF_THRESH (3),
    .AE_THRESH (1)
  ) dut_a (
    .clock        (clock),
    .reset_L      (reset_L),
    .clear        (clear),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (a_rd_data),
    .empty        (a_empty),
    .full         (a_full),
    .almost_empty (a_ae),
    .almost_full  (a_af),
    .count        (a_count),
    .overflow     (a_ovf),
    .underflow    (a_unf)
  );

  sync_fifo #(
    .DW        (8),
    .DEPTH     (5),
    .AF_THRESH (4),
    .AE_THRESH (1)
  ) dut_b (
    .clock        (clock),
    .reset_L      (reset_L),
    .clear        (clear),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_data      (b_rd_data),
    .empty        (b_empty),
    .full         (b_full),
    .almost_empty (b_ae),
    .almost_full  (b_af),
    .count        (b_count),
    .overflow     (b_ovf),
    .underflow    (b_unf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic fill4();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_data = vals[i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset_L = 1'b0;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 8'hFF;
    tick();
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_checks++;
    if ({a_empty, a_full, a_ae, a_af, a_ovf, a_unf} !== 6'b101000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 101000",
               {a_empty, a_full, a_ae, a_af, a_ovf, a_unf});
    end
    n_checks++;
    if (a_count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d expected 0", a_count);
    end
    reset_L = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      wr_en   = 1'b1;
      wr_data = vals[i];
      tick();
      wr_en = 1'b0;
      n_checks++;
      if (a_count !== 3'(i + 1)) begin
        n_fail++;
        $display("FAIL fill_count[%0d]: got %0d expected %0d", i, a_count, i + 1);
      end
      n_checks++;
      if (a_rd_data !== 8'h11) begin
        n_fail++;
        $display("FAIL fill_head[%0d]: got %h expected 11", i, a_rd_data);
      end
      n_checks++;
      if (a_af !== (i + 1 >= 3)) begin
        n_fail++;
        $display("FAIL fill_almost_full[%0d]: got %b expected %b", i, a_af, (i + 1 >= 3));
      end
      n_checks++;
      if (a_full !== (i + 1 == 4)) begin
        n_fail++;
        $display("FAIL fill_full[%0d]: got %b expected %b", i, a_full, (i + 1 == 4));
      end
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (a_rd_data !== vals[i]) begin
        n_fail++;
        $display("FAIL drain_data[%0d]: got %h expected %h", i, a_rd_data, vals[i]);
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    n_checks++;
    if (a_empty !== 1'b1 || a_count !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_empty: got empty=%b count=%0d expected empty=1 count=0",
               a_empty, a_count);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    fill4();
    wr_en   = 1'b1;
    wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    n_checks++;
    if (a_ovf !== 1'b1 || a_count !== 3'd4 || a_full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_set: got ovf=%b count=%0d full=%b expected 1/4/1",
               a_ovf, a_count, a_full);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (a_rd_data !== vals[i]) begin
        n_fail++;
        $display("FAIL overflow_drain[%0d]: got %h expected %h", i, a_rd_data, vals[i]);
      end
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    n_checks++;
    if (a_ovf !== 1'b1 || a_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_sticky: got ovf=%b empty=%b expected 1/1", a_ovf, a_empty);
    end
    do_clear();
  endtask

  task automatic test_full_push_pop();
    fill4();
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 8'h66;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_checks++;
    if (a_rd_data !== 8'h22 || a_count !== 3'd4 || a_full !== 1'b1 || a_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pushpop: got data=%h count=%0d full=%b ovf=%b expected 22/4/1/0",
               a_rd_data, a_count, a_full, a_ovf);
    end
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
    end
    n_checks++;
    if (a_rd_data !== 8'h66 || a_count !== 3'd1) begin
      n_fail++;
      $display("FAIL full_pushpop_tail: got data=%h count=%0d expected 66/1",
               a_rd_data, a_count);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_underflow();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (a_unf !== 1'b1 || a_count !== 3'd0 || a_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_set: got unf=%b count=%0d empty=%b expected 1/0/1",
               a_unf, a_count, a_empty);
    end
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 8'h77;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b0;
    n_checks++;
    if (a_count !== 3'd1 || a_rd_data !== 8'h77 || a_unf !== 1'b1) begin
      n_fail++;
      $display("FAIL underflow_pushpop: got count=%0d data=%h unf=%b expected 1/77/1",
               a_count, a_rd_data, a_unf);
    end
  endtask

  task automatic test_clear();
    wr_en   = 1'b1;
    wr_data = 8'hA1;
    tick();
    clear   = 1'b1;
    wr_data = 8'hEE;
    tick();
    clear = 1'b0;
    wr_en = 1'b0;
    n_checks++;
    if (a_count !== 3'd0 || a_empty !== 1'b1 || a_ovf !== 1'b0 || a_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_state: got count=%0d empty=%b ovf=%b unf=%b expected 0/1/0/0",
               a_count, a_empty, a_ovf, a_unf);
    end
    wr_en   = 1'b1;
    wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    n_checks++;
    if (a_count !== 3'd1 || a_rd_data !== 8'h5A) begin
      n_fail++;
      $display("FAIL clear_nostore: got count=%0d data=%h expected 1/5a", a_count, a_rd_data);
    end
    do_clear();
  endtask

  task automatic test_wrap();
    logic [7:0] exp_q [$];
    do_clear();
    for (int i = 0; i < 2; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'(8'h01 + i);
      exp_q.push_back(wr_data);
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = 8'(8'h10 + i);
      exp_q.push_back(wr_data);
      void'(exp_q.pop_front());
      tick();
      n_checks++;
      if (a_rd_data !== exp_q[0] || a_count !== 3'd2) begin
        n_fail++;
        $display("FAIL wrap_d4[%0d]: got data=%h count=%0d expected %h/2",
                 i, a_rd_data, a_count, exp_q[0]);
      end
      n_checks++;
      if (b_rd_data !== exp_q[0] || b_count !== 4'd2) begin
        n_fail++;
        $display("FAIL wrap_d5[%0d]: got data=%h count=%0d expected %h/2",
                 i, b_rd_data, b_count, exp_q[0]);
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    do_clear();
  endtask

  task automatic test_random();
    logic [7:0] q4 [$];
    logic [7:0] q5 [$];
    bit ovf4, unf4, ovf5, unf5;
    bit pop_ok, push_ok;
    logic [5:0] exp_flags;
    ovf4 = 0; unf4 = 0; ovf5 = 0; unf5 = 0;
    for (int n = 0; n < 400; n++) begin
      // Alternate fill-biased and drain-biased phases so both full and empty get exercised.
      if ((n / 40) % 2 == 0) begin
        wr_en = ($urandom_range(3, 0) != 0);
        rd_en = ($urandom_range(3, 0) == 0);
      end else begin
        wr_en = ($urandom_range(3, 0) == 0);
        rd_en = ($urandom_range(3, 0) != 0);
      end
      wr_data = 8'($urandom);
      clear   = ($urandom_range(49, 0) == 0);
      tick();
      if (clear) begin
        q4.delete(); q5.delete();
        ovf4 = 0; unf4 = 0; ovf5 = 0; unf5 = 0;
      end else begin
        pop_ok  = rd_en && q4.size() > 0;
        push_ok = wr_en && (q4.size() < 4 || pop_ok);
        if (rd_en && q4.size() == 0) unf4 = 1;
        if (wr_en && !push_ok) ovf4 = 1;
        if (pop_ok) void'(q4.pop_front());
        if (push_ok) q4.push_back(wr_data);
        pop_ok  = rd_en && q5.size() > 0;
        push_ok = wr_en && (q5.size() < 5 || pop_ok);
        if (rd_en && q5.size() == 0) unf5 = 1;
        if (wr_en && !push_ok) ovf5 = 1;
        if (pop_ok) void'(q5.pop_front());
        if (push_ok) q5.push_back(wr_data);
      end
      exp_flags = {q4.size() == 0, q4.size() == 4, q4.size() <= 1, q4.size() >= 3, ovf4, unf4};
      n_checks++;
      if ({a_empty, a_full, a_ae, a_af, a_ovf, a_unf} !== exp_flags) begin
        n_fail++;
        $display("FAIL rand_d4_flags[%0d]: got %b expected %b", n,
                 {a_empty, a_full, a_ae, a_af, a_ovf, a_unf}, exp_flags);
      end
      n_checks++;
      if (a_count !== 3'(q4.size())) begin
        n_fail++;
        $display("FAIL rand_d4_count[%0d]: got %0d expected %0d", n, a_count, q4.size());
      end
      if (q4.size() > 0) begin
        n_checks++;
        if (a_rd_data !== q4[0]) begin
          n_fail++;
          $display("FAIL rand_d4_data[%0d]: got %h expected %h", n, a_rd_data, q4[0]);
        end
      end
      exp_flags = {q5.size() == 0, q5.size() == 5, q5.size() <= 1, q5.size() >= 4, ovf5, unf5};
      n_checks++;
      if ({b_empty, b_full, b_ae, b_af, b_ovf, b_unf} !== exp_flags) begin
        n_fail++;
        $display("FAIL rand_d5_flags[%0d]: got %b expected %b", n,
                 {b_empty, b_full, b_ae, b_af, b_ovf, b_unf}, exp_flags);
      end
      n_checks++;
      if (b_count !== 4'(q5.size())) begin
        n_fail++;
        $display("FAIL rand_d5_count[%0d]: got %0d expected %0d", n, b_count, q5.size());
      end
      if (q5.size() > 0) begin
        n_checks++;
        if (b_rd_data !== q5[0]) begin
          n_fail++;
          $display("FAIL rand_d5_data[%0d]: got %h expected %h", n, b_rd_data, q5[0]);
        end
      end
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_L  = 1'b0;
    clear    = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    wr_data  = '0;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_clear();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
